// File: rtl/rr_arb8.sv
// rr_arb8 -- round-robin arbiter/sequencer sharing one datapath port among
// 8 requesters. A grant is held for a multi-beat burst until the owner's
// final beat (last) is accepted. If the owner drops req mid-burst for
// TIMEOUT consecutive cycles, the grant is force-released.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   req[7:0]         requester i has a valid beat
//   last[7:0]        requester i's current beat ends its burst (qualified by req)
//   out_ready        downstream accepts the current beat
//   sel[2:0]         current owner index, drives the downstream 8:1 data mux
//   grant[7:0]       one-hot owner, 0 when idle
//   ack[7:0]         per-requester beat accept (combinational)
//   out_valid        busy & req[sel]
//   out_last         out_valid & last[sel]
//   busy             grant held
//   timeout_err      one-cycle pulse after a forced release

// Per-requester slice: beat accept and candidate bit for back-to-back
// re-arbitration (the outgoing owner is masked so it cannot win again).
module rr_arb8_lane (
  input  logic grant,
  input  logic req,
  input  logic out_ready,
  output logic ack,
  output logic cand
);
  assign ack  = grant & req & out_ready;
  assign cand = req & ~grant;
endmodule

module rr_arb8 #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic [7:0] ack,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       timeout_err
);

  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  state_t          state, state_n;
  logic [2:0]      sel_n;
  logic [7:0]      grant_n;
  logic [2:0]      ptr, ptr_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic            terr_n;

  logic [NUM_LANES-1:0] cand;
  logic [2:0]           sel_inc;
  logic                 beat_fin;
  pick_t                pick_idle, pick_next;

  // First set bit of r searching p, p+1, ..., 7, 0, ..., p-1.
  // Rotating right by p turns the search into a plain lowest-bit find.
  function automatic pick_t rr_pick(input logic [7:0] r, input logic [2:0] p);
    pick_t      res;
    logic [15:0] sh;
    logic [7:0]  rot;
    sh        = {r, r} >> p;
    rot       = sh[7:0];
    res.found = |r;
    res.idx   = p;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (rot[k]) res.idx = p + 3'(k);
    end
    return res;
  endfunction

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rr_arb8_lane u_lane (
      .grant     (grant[i]),
      .req       (req[i]),
      .out_ready (out_ready),
      .ack       (ack[i]),
      .cand      (cand[i])
    );
  end

  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign out_last  = out_valid & last[sel];
  assign beat_fin  = out_last & out_ready;
  assign sel_inc   = sel + 3'd1;

  // Idle search uses the stored pointer; the back-to-back search uses the
  // pointer being written on this edge, so the just-finished owner is last.
  assign pick_idle = rr_pick(req, ptr);
  assign pick_next = rr_pick(cand, sel_inc);

  always_comb begin
    state_n = state;
    sel_n   = sel;
    grant_n = grant;
    ptr_n   = ptr;
    cnt_n   = cnt;
    terr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_idle.found) begin
          state_n = GRANT;
          sel_n   = pick_idle.idx;
          grant_n = 8'd1 << pick_idle.idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (beat_fin) begin
          ptr_n = sel_inc;
          cnt_n = '0;
          if (pick_next.found) begin
            sel_n   = pick_next.idx;
            grant_n = 8'd1 << pick_next.idx;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end else if (req[sel]) begin
          // Owner present (accepted or back-pressured): not stalled.
          cnt_n = '0;
        end else if (cnt == TO_W'(TIMEOUT - 1)) begin
          // Owner vanished mid-burst too long; free the port, no re-arbitration.
          state_n = IDLE;
          grant_n = '0;
          ptr_n   = sel_inc;
          cnt_n   = '0;
          terr_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      grant       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      grant       <= grant_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: reset, single beat, round-robin wrap,
// multi-beat burst, back-pressure, timeout release, reset mid-burst.
module tb_rr_arb8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, last;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] grant, ack;
  logic       out_valid, out_last, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  rr_arb8 #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .last        (last),
    .out_ready   (out_ready),
    .sel         (sel),
    .grant       (grant),
    .ack         (ack),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = 8'h00; last = 8'h00; out_ready = 1'b0;
    cyc;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 8'hFF; last = 8'hFF; out_ready = 1'b1;
    cyc; cyc;
    checks++;
    if ({grant, sel, busy} !== 12'h000) begin
      errors++; $display("FAIL reset_state: grant/sel/busy got %h expected 000", {grant, sel, busy});
    end
    checks++;
    if ({ack, out_valid, out_last, timeout_err} !== 11'h000) begin
      errors++; $display("FAIL reset_comb: ack/ov/ol/terr got %h expected 000", {ack, out_valid, out_last, timeout_err});
    end
    rst = 1'b0; req = 8'h00; last = 8'h00;
    cyc;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_single;
    do_reset;
    req = 8'h01; last = 8'h01; out_ready = 1'b1;
    cyc;
    checks++;
    if ({grant, sel, out_valid, ack, out_last, busy} !== {8'h01, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1}) begin
      errors++; $display("FAIL single_grant: grant %h sel %0d ov %b ack %h ol %b busy %b", grant, sel, out_valid, ack, out_last, busy);
    end
    cyc;
    checks++;
    if ({busy, grant, sel} !== {1'b0, 8'h00, 3'd0}) begin
      errors++; $display("FAIL single_release: busy %b grant %h sel %0d expected 0 00 0", busy, grant, sel);
    end
    // ptr now 1: with requesters 0 and 1, requester 1 must win.
    req = 8'h03; last = 8'h03;
    cyc;
    checks++;
    if ({sel, grant} !== {3'd1, 8'h02}) begin
      errors++; $display("FAIL single_ptr: sel %0d grant %h expected 1 02", sel, grant);
    end
    req = 8'h02; last = 8'h02;
    cyc;
    checks++;
    if ({busy, sel} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL single_sel_hold: busy %b sel %0d expected 0 1", busy, sel);
    end
    req = 8'h00; last = 8'h00;
  endtask

  task automatic test_rr_wrap;
    logic [2:0] e;
    logic [7:0] one;
    do_reset;
    req = 8'hFF; last = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc;
      e   = 3'(i % 8);
      one = 8'd1 << e;
      checks++;
      if ({sel, grant, out_valid, busy} !== {e, one, 1'b1, 1'b1}) begin
        errors++; $display("FAIL rr_wrap[%0d]: sel %0d grant %h ov %b busy %b expected sel %0d grant %h", i, sel, grant, out_valid, busy, e, one);
      end
    end
    req = 8'h00; last = 8'h00;
  endtask

  task automatic test_burst;
    do_reset;
    req = 8'h28; last = 8'h20; out_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      cyc;
      if (b == 4) last = 8'h28;
      #1;
      checks++;
      if ({sel, ack, out_last} !== {3'd3, 8'h08, (b == 4)}) begin
        errors++; $display("FAIL burst_beat%0d: sel %0d ack %h ol %b", b, sel, ack, out_last);
      end
    end
    cyc;
    checks++;
    if ({sel, grant, ack, out_last} !== {3'd5, 8'h20, 8'h20, 1'b1}) begin
      errors++; $display("FAIL burst_next: sel %0d grant %h ack %h ol %b expected 5 20 20 1", sel, grant, ack, out_last);
    end
    // ptr 6 wraps past 7 to find requester 3 again.
    cyc;
    checks++;
    if ({sel, grant} !== {3'd3, 8'h08}) begin
      errors++; $display("FAIL burst_wrap: sel %0d grant %h expected 3 08", sel, grant);
    end
    req = 8'h00; last = 8'h00;
  endtask

  task automatic test_stall;
    do_reset;
    req = 8'h04; last = 8'h00; out_ready = 1'b1;
    cyc; cyc;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({out_valid, sel, ack, grant, timeout_err} !== {1'b1, 3'd2, 8'h00, 8'h04, 1'b0}) begin
        errors++; $display("FAIL stall[%0d]: ov %b sel %0d ack %h grant %h terr %b", i, out_valid, sel, ack, grant, timeout_err);
      end
      cyc;
    end
    out_ready = 1'b1; last = 8'h04;
    #1;
    checks++;
    if ({ack, out_last} !== {8'h04, 1'b1}) begin
      errors++; $display("FAIL stall_resume: ack %h ol %b expected 04 1", ack, out_last);
    end
    cyc;
    checks++;
    if ({busy, grant, sel, timeout_err} !== {1'b0, 8'h00, 3'd2, 1'b0}) begin
      errors++; $display("FAIL stall_done: busy %b grant %h sel %0d terr %b", busy, grant, sel, timeout_err);
    end
    req = 8'h00; last = 8'h00;
  endtask

  task automatic test_timeout;
    do_reset;
    req = 8'h04; last = 8'h00; out_ready = 1'b1;
    cyc; cyc;
    req = 8'h00;
    for (int i = 1; i <= 15; i++) begin
      cyc;
      checks++;
      if ({busy, grant, timeout_err} !== {1'b1, 8'h04, 1'b0}) begin
        errors++; $display("FAIL timeout_hold[%0d]: busy %b grant %h terr %b", i, busy, grant, timeout_err);
      end
    end
    cyc;
    checks++;
    if ({busy, grant, timeout_err} !== {1'b0, 8'h00, 1'b1}) begin
      errors++; $display("FAIL timeout_release: busy %b grant %h terr %b expected 0 00 1", busy, grant, timeout_err);
    end
    req = 8'h05;
    cyc;
    checks++;
    if ({timeout_err, busy, sel, grant} !== {1'b0, 1'b1, 3'd0, 8'h01}) begin
      errors++; $display("FAIL timeout_next: terr %b busy %b sel %0d grant %h expected 0 1 0 01", timeout_err, busy, sel, grant);
    end
    req = 8'h00;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 8'h04; last = 8'h04; out_ready = 1'b1;
    cyc;
    req = 8'h44;
    cyc;
    checks++;
    if ({sel, grant} !== {3'd6, 8'h40}) begin
      errors++; $display("FAIL rstmid_b2b: sel %0d grant %h expected 6 40", sel, grant);
    end
    req = 8'h40; last = 8'h00;
    cyc;
    rst = 1'b1;
    cyc;
    rst = 1'b0; req = 8'h41;
    #1;
    checks++;
    if ({grant, sel, busy, ack, out_valid, timeout_err} !== 22'h0) begin
      errors++; $display("FAIL rstmid_clear: grant %h sel %0d busy %b ack %h ov %b terr %b", grant, sel, busy, ack, out_valid, timeout_err);
    end
    cyc;
    checks++;
    if ({sel, grant} !== {3'd0, 8'h01}) begin
      errors++; $display("FAIL rstmid_ptr: sel %0d grant %h expected 0 01", sel, grant);
    end
    req = 8'h00;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; last = 8'h00; out_ready = 1'b0;
    test_reset;
    test_single;
    test_rr_wrap;
    test_burst;
    test_stall;
    test_timeout;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
